mem_port_arbiter: RTL and testbench

//  Shares the single-ported main memory between the CPU control unit (fetch/load/store) and a
//  DMA/debug loader port. Sequences each access over a fixed memory latency, returns read data,
//  and produces the per-requester ready pulse that drives the control unit's iRdy step gating.
//  CPU has priority; a burst limit stops the DMA port from starving.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_arb_prio.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, requester ids, access ops.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_PORT_CPU = 1'b0,
    ARB_PORT_DMA = 1'b1
  } arb_port_e;

  typedef enum logic {
    ARB_OP_RD = 1'b0,
    ARB_OP_WR = 1'b1
  } arb_op_e;

  // Read and write together on one port resolve to a write.
  function automatic arb_op_e arb_op_sel(input logic wr);
    return wr ? ARB_OP_WR : ARB_OP_RD;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between CPU and DMA: CPU wins unless DMA has waited through CPU_BURST
// consecutive CPU grants. The streak counter advances only when a grant is taken.
module mem_arb_prio
  import mem_port_arbiter_pkg::*;
#(
  parameter int CPU_BURST = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      arb_en,
  input  logic      cpu_req,
  input  logic      dma_req,
  output logic      gnt_vld,
  output arb_port_e gnt_port
);

  localparam int SW = $clog2(CPU_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(CPU_BURST);

  logic [SW-1:0] streak_q, streak_d;
  logic          dma_win;

  always_comb begin
    dma_win  = dma_req && (!cpu_req || (streak_q >= STREAK_MAX));
    gnt_vld  = arb_en && (cpu_req || dma_req);
    gnt_port = dma_win ? ARB_PORT_DMA : ARB_PORT_CPU;
    streak_d = streak_q;
    if (gnt_vld) begin
      if (dma_win) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between CPU and DMA requesters: IDLE -> ACCESS (LATENCY cycles)
// -> DONE (one-cycle Rdy pulse to the granted port, registered read data).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 2,
  parameter int CPU_BURST = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCPU_Read,
  input  logic              iCPU_Write,
  input  logic [ADDR_W-1:0] iCPU_Addr,
  input  logic [DATA_W-1:0] iCPU_WData,
  output logic [DATA_W-1:0] oCPU_RData,
  output logic              oCPU_Rdy,
  input  logic              iDMA_Read,
  input  logic              iDMA_Write,
  input  logic [ADDR_W-1:0] iDMA_Addr,
  input  logic [DATA_W-1:0] iDMA_WData,
  output logic [DATA_W-1:0] oDMA_RData,
  output logic              oDMA_Rdy,
  output logic [ADDR_W-1:0] oMem_Addr,
  output logic [DATA_W-1:0] oMem_WData,
  output logic              oMem_Read,
  output logic              oMem_Write,
  input  logic [DATA_W-1:0] iMem_Data,
  output logic              oBusy
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  arb_state_e        state_q, state_d;
  arb_port_e         port_q, port_d;
  arb_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic      cpu_req, dma_req;
  logic      gnt_vld;
  arb_port_e gnt_port;

  assign cpu_req = iCPU_Read | iCPU_Write;
  assign dma_req = iDMA_Read | iDMA_Write;

  mem_arb_prio #(
    .CPU_BURST (CPU_BURST)
  ) u_prio (
    .clk      (iClk),
    .rst      (iRst),
    .arb_en   (state_q == ARB_IDLE),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .gnt_vld  (gnt_vld),
    .gnt_port (gnt_port)
  );

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (gnt_vld) begin
          state_d = ARB_ACCESS;
          port_d  = gnt_port;
          cnt_d   = CNT_INIT;
          if (gnt_port == ARB_PORT_DMA) begin
            op_d    = arb_op_sel(iDMA_Write);
            addr_d  = iDMA_Addr;
            wdata_d = iDMA_WData;
          end else begin
            op_d    = arb_op_sel(iCPU_Write);
            addr_d  = iCPU_Addr;
            wdata_d = iCPU_WData;
          end
        end
      end
      ARB_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ARB_DONE;
          // Write completions return zero data to the requester.
          if (port_q == ARB_PORT_DMA) begin
            dma_rdata_d = (op_q == ARB_OP_RD) ? iMem_Data : '0;
          end else begin
            cpu_rdata_d = (op_q == ARB_OP_RD) ? iMem_Data : '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_DONE: begin
        state_d     = ARB_IDLE;
        cpu_rdata_d = '0;
        dma_rdata_d = '0;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= ARB_IDLE;
      port_q      <= ARB_PORT_CPU;
      op_q        <= ARB_OP_RD;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Strobes and Rdy decode straight from flops, so reset drops them without a clock.
  always_comb begin
    oMem_Addr  = addr_q;
    oMem_WData = wdata_q;
    oMem_Read  = (state_q == ARB_ACCESS) && (op_q == ARB_OP_RD);
    oMem_Write = (state_q == ARB_ACCESS) && (op_q == ARB_OP_WR);
    oCPU_Rdy   = (state_q == ARB_DONE) && (port_q == ARB_PORT_CPU);
    oDMA_Rdy   = (state_q == ARB_DONE) && (port_q == ARB_PORT_DMA);
    oCPU_RData = cpu_rdata_q;
    oDMA_RData = dma_rdata_q;
    oBusy      = (state_q == ARB_ACCESS) || (state_q == ARB_DONE);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, random traffic.
module tb_mem_port_arbiter;

  localparam int LAT   = 2;
  localparam int BURST = 4;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iCPU_Read = 0, iCPU_Write = 0, iDMA_Read = 0, iDMA_Write = 0;
  logic [31:0] iCPU_Addr = 0, iCPU_WData = 0, iDMA_Addr = 0, iDMA_WData = 0;
  logic [31:0] oCPU_RData, oDMA_RData, oMem_Addr, oMem_WData, iMem_Data;
  logic        oCPU_Rdy, oDMA_Rdy, oMem_Read, oMem_Write, oBusy;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_val = 32'h0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 iClk = ~iClk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .CPU_BURST(BURST)
  ) dut (
    .iClk(iClk), .iRst(iRst),
    .iCPU_Read(iCPU_Read), .iCPU_Write(iCPU_Write), .iCPU_Addr(iCPU_Addr),
    .iCPU_WData(iCPU_WData), .oCPU_RData(oCPU_RData), .oCPU_Rdy(oCPU_Rdy),
    .iDMA_Read(iDMA_Read), .iDMA_Write(iDMA_Write), .iDMA_Addr(iDMA_Addr),
    .iDMA_WData(iDMA_WData), .oDMA_RData(oDMA_RData), .oDMA_Rdy(oDMA_Rdy),
    .oMem_Addr(oMem_Addr), .oMem_WData(oMem_WData), .oMem_Read(oMem_Read),
    .oMem_Write(oMem_Write), .iMem_Data(iMem_Data), .oBusy(oBusy)
  );

  // Behavioural memory: contents are a fixed hash of the address unless overridden.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always_comb iMem_Data = ovr_en ? ovr_val : mem_fn(oMem_Addr);

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drop_all();
    iCPU_Read = 0; iCPU_Write = 0; iDMA_Read = 0; iDMA_Write = 0;
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    drop_all();
    step();
    step();
    iRst = 1'b0;
  endtask

  // Entered in an IDLE cycle with requests applied; returns in the following IDLE cycle.
  task automatic do_txn(input string tag, input bit exp_dma, input bit exp_wr,
                        input logic [31:0] exp_addr, input logic [31:0] exp_wd,
                        input logic [31:0] exp_rd, input bit mut);
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (mut && k == 1) begin
        iCPU_Addr = 32'h20; iCPU_Read = 0; iCPU_Write = 0;
      end
      check({tag, "_strobe"}, {62'd0, oMem_Read, oMem_Write}, {62'd0, !exp_wr, exp_wr});
      check({tag, "_addr"}, {32'd0, oMem_Addr}, {32'd0, exp_addr});
      if (exp_wr) check({tag, "_wdata"}, {32'd0, oMem_WData}, {32'd0, exp_wd});
      check({tag, "_acc_rdy_busy"}, {61'd0, oCPU_Rdy, oDMA_Rdy, oBusy}, 64'd1);
    end
    step();
    check({tag, "_done_rdy"}, {62'd0, oCPU_Rdy, oDMA_Rdy}, exp_dma ? 64'd1 : 64'd2);
    check({tag, "_cpu_rdata"}, {32'd0, oCPU_RData}, {32'd0, exp_dma ? 32'd0 : exp_rd});
    check({tag, "_dma_rdata"}, {32'd0, oDMA_RData}, {32'd0, exp_dma ? exp_rd : 32'd0});
    check({tag, "_done_strobe_busy"}, {61'd0, oMem_Read, oMem_Write, oBusy}, 64'd1);
    step();
    check({tag, "_idle"}, {61'd0, oCPU_Rdy, oDMA_Rdy, oBusy}, 64'd0);
  endtask

  typedef struct {
    logic        c_rd, c_wr;
    logic [31:0] c_addr, c_wd;
    logic        d_rd, d_wr;
    logic [31:0] d_addr, d_wd, mem_val;
    logic        exp_dma, exp_wr;
    logic [31:0] exp_addr, exp_wd, exp_rd;
  } vec_t;

  vec_t vt[7];

  initial begin
    bit          ord[10];
    bit          pc, pd, c_rd, c_wr, d_rd, d_wr, win_dma;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    int          streak;
    int          op;

    vt[0] = '{1,0,32'h40,0,          0,1,32'h80,32'h1234_5678,32'hDEAD_BEEF, 0,0,32'h40,0,32'hDEAD_BEEF};
    vt[1] = '{0,0,0,0,               0,1,32'h80,32'h1234_5678,32'h0000_0077, 1,1,32'h80,32'h1234_5678,0};
    vt[2] = '{1,1,32'h30,32'hCAFE_0001, 0,0,0,0,32'h0000_0077,            0,1,32'h30,32'hCAFE_0001,0};
    vt[3] = '{0,0,0,0,               1,1,32'h44,32'hABCD_0000,32'h0000_0077, 1,1,32'h44,32'hABCD_0000,0};
    vt[4] = '{1,0,32'h100,0,         1,0,32'h200,0,32'h1111_2222,          0,0,32'h100,0,32'h1111_2222};
    vt[5] = '{0,0,0,0,               1,0,32'hFFFF_FFFC,0,32'hFFFF_FFFF,    1,0,32'hFFFF_FFFC,0,32'hFFFF_FFFF};
    vt[6] = '{0,1,32'h8,32'h0,       0,0,0,0,32'h0000_0009,                0,1,32'h8,0,0};

    // Reset state
    step();
    step();
    check("rst_ctrl", {57'd0, oMem_Read, oMem_Write, oCPU_Rdy, oDMA_Rdy, oBusy}, 64'd0);
    check("rst_mem_bus", {oMem_Addr, oMem_WData}, 64'd0);
    check("rst_rdata", {oCPU_RData, oDMA_RData}, 64'd0);
    iRst = 1'b0;

    // Reset asserted mid-ACCESS aborts the access with no Rdy
    iCPU_Read = 1; iCPU_Addr = 32'h10;
    step();
    check("abort_pre_strobe", {63'd0, oMem_Read}, 64'd1);
    #2 iRst = 1'b1;
    #1 check("abort_async_drop", {60'd0, oMem_Read, oMem_Write, oBusy, oCPU_Rdy}, 64'd0);
    iCPU_Read = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_rdy", {62'd0, oCPU_Rdy, oDMA_Rdy}, 64'd0);
    end
    iRst = 1'b0;
    step();
    check("abort_idle", {60'd0, oMem_Read, oMem_Write, oBusy, oCPU_Rdy}, 64'd0);

    // Directed vector table, starting from a fresh streak
    do_reset();
    ovr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      iCPU_Read = vt[i].c_rd; iCPU_Write = vt[i].c_wr;
      iCPU_Addr = vt[i].c_addr; iCPU_WData = vt[i].c_wd;
      iDMA_Read = vt[i].d_rd; iDMA_Write = vt[i].d_wr;
      iDMA_Addr = vt[i].d_addr; iDMA_WData = vt[i].d_wd;
      ovr_val = vt[i].mem_val;
      do_txn($sformatf("vec%0d", i), vt[i].exp_dma, vt[i].exp_wr, vt[i].exp_addr,
             vt[i].exp_wd, vt[i].exp_rd, 1'b0);
      drop_all();
    end
    ovr_en = 1'b0;

    // Both requesters held continuously: four CPU grants per DMA grant
    do_reset();
    ord = '{0,0,0,0,1,0,0,0,0,1};
    iCPU_Read = 1; iCPU_Addr = 32'h100;
    iDMA_Read = 1; iDMA_Addr = 32'h200;
    for (int i = 0; i < 10; i++) begin
      do_txn($sformatf("burst%0d", i), ord[i], 1'b0, ord[i] ? 32'h200 : 32'h100, 32'h0,
             mem_fn(ord[i] ? 32'h200 : 32'h100), 1'b0);
    end
    drop_all();

    // Address change and request drop during ACCESS are ignored
    ovr_en = 1'b1; ovr_val = 32'h5555_AAAA;
    iCPU_Read = 1; iCPU_Addr = 32'h10;
    do_txn("mid_change", 1'b0, 1'b0, 32'h10, 32'h0, 32'h5555_AAAA, 1'b1);
    step();
    check("mid_change_single", {61'd0, oCPU_Rdy, oBusy, oMem_Read}, 64'd0);
    ovr_en = 1'b0;

    // Random traffic against a transaction-level model
    do_reset();
    streak = 0; pc = 0; pd = 0;
    c_rd = 0; c_wr = 0; d_rd = 0; d_wr = 0;
    c_addr = 0; c_wd = 0; d_addr = 0; d_wd = 0;
    for (int it = 0; it < 200; it++) begin
      if (!pc && $urandom_range(0, 9) < 6) begin
        pc = 1; op = $urandom_range(0, 2);
        c_rd = (op != 1); c_wr = (op != 0);
        c_addr = $urandom; c_wd = $urandom;
      end
      if (!pd && $urandom_range(0, 9) < 6) begin
        pd = 1; op = $urandom_range(0, 2);
        d_rd = (op != 1); d_wr = (op != 0);
        d_addr = $urandom; d_wd = $urandom;
      end
      iCPU_Read = pc & c_rd; iCPU_Write = pc & c_wr; iCPU_Addr = c_addr; iCPU_WData = c_wd;
      iDMA_Read = pd & d_rd; iDMA_Write = pd & d_wr; iDMA_Addr = d_addr; iDMA_WData = d_wd;
      if (!pc && !pd) begin
        step();
        check("rnd_idle", {59'd0, oBusy, oMem_Read, oMem_Write, oCPU_Rdy, oDMA_Rdy}, 64'd0);
        continue;
      end
      win_dma = pd && (!pc || streak >= BURST);
      streak = win_dma ? 0 : ((streak < BURST) ? streak + 1 : BURST);
      if (win_dma) begin
        do_txn($sformatf("rnd%0d_dma", it), 1'b1, d_wr, d_addr, d_wd,
               d_wr ? 32'd0 : mem_fn(d_addr), 1'b0);
        pd = 0;
      end else begin
        do_txn($sformatf("rnd%0d_cpu", it), 1'b0, c_wr, c_addr, c_wd,
               c_wr ? 32'd0 : mem_fn(c_addr), 1'b0);
        pc = 0;
      end
    end
    drop_all();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
